led_array_module: RTL and testbench

LED_ARRAY_MODULE -- requirements
Module: led_array_module

---
 rtl/led_array_module.sv | 132 +++++++++++++
 tb/tb_led_array_module.sv | 119 +++++++++++
 2 files changed

// File: rtl/led_array_module.sv
// Multi-channel LED driver: 256-slot PWM frames with per-channel off/on/blink/breathe modes.
// Define LED_BREATHE_EN to build the breathe level logic; without it, mode 11 behaves as blink.
module led_array_module #(
  parameter int CHANNELS = 4,
  parameter int STEP     = 19531,
  parameter int PRE_W    = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [2*CHANNELS-1:0]   Mode,
  input  logic [8*CHANNELS-1:0]   Duty,
  output logic [CHANNELS-1:0]     LED_Out,
  output logic                    Frame_Tick
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [7:0]          slot_q, slot_d;
  logic                tick_q;
  logic [CHANNELS-1:0] led_q;
  logic [CHANNELS-1:0] led_d;
  logic                slot_wrap;
  logic                frame_start;

  assign slot_wrap   = EN && (pre_q == PRE_LAST);
  assign frame_start = slot_wrap && (slot_q == 8'hFF);

  always_comb begin
    pre_d  = pre_q;
    slot_d = slot_q;
    if (EN) begin
      if (slot_wrap) begin
        pre_d  = '0;
        slot_d = (slot_q == 8'hFF) ? 8'h00 : slot_q + 8'd1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q  <= '0;
      slot_q <= '0;
      tick_q <= 1'b0;
      led_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      slot_q <= slot_d;
      tick_q <= frame_start;
      led_q  <= EN ? led_d : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [1:0] mode_in;
      logic [7:0] duty_in;
      logic [1:0] mode_q;
      logic [7:0] duty_q;
      logic [7:0] thresh;

      assign mode_in = Mode[2*gi +: 2];
      assign duty_in = Duty[8*gi +: 8];

      // Shadows only move at frame boundaries so a frame never shows a mixed setting.
      always_ff @(posedge CLK) begin
        if (RST) begin
          mode_q <= 2'b00;
          duty_q <= 8'h00;
        end else if (frame_start) begin
          mode_q <= mode_in;
          duty_q <= duty_in;
        end
      end

`ifdef LED_BREATHE_EN
      logic [7:0] level_q, level_d;
      logic       down_q, down_d;

      always_comb begin
        level_d = level_q;
        down_d  = down_q;
        if (frame_start) begin
          if (mode_in != 2'b11) begin
            level_d = 8'h00;
            down_d  = 1'b0;
          end else if (!down_q) begin
            if (level_q == 8'hFF) begin
              level_d = 8'hFE;
              down_d  = 1'b1;
            end else begin
              level_d = level_q + 8'd1;
            end
          end else begin
            if (level_q == 8'h00) begin
              level_d = 8'h01;
              down_d  = 1'b0;
            end else begin
              level_d = level_q - 8'd1;
            end
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          level_q <= 8'h00;
          down_q  <= 1'b0;
        end else begin
          level_q <= level_d;
          down_q  <= down_d;
        end
      end

      assign thresh = (mode_q == 2'b11) ? level_q : duty_q;
`else
      assign thresh = duty_q;
`endif

      // 01 is steady on; 10 and 11 both compare the slot against a threshold.
      assign led_d[gi] = (mode_q == 2'b01) | (mode_q[1] & (slot_q < thresh));
    end
  endgenerate

  assign LED_Out    = led_q;
  assign Frame_Tick = tick_q;

endmodule

// File: tb/tb_led_array_module.sv
// Directed bench for led_array_module with STEP=4, CHANNELS=2 (1024-cycle frames).
// Breathe expectations follow LED_BREATHE_EN; otherwise ch1 is expected to act as blink.
module tb_led_array_module;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [3:0] Mode;
  logic [15:0] Duty;
  logic [1:0] LED_Out;
  logic       Frame_Tick;

  int n_checks = 0;
  int n_fail   = 0;

  led_array_module #(.CHANNELS(2), .STEP(4), .PRE_W(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .Mode       (Mode),
    .Duty       (Duty),
    .LED_Out    (LED_Out),
    .Frame_Tick (Frame_Tick)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ch1 runs mode 11 with duty 16: breathe gives level*4 cycles, blink gives 16*4.
  function automatic int exp_h1(input int lvl);
`ifdef LED_BREATHE_EN
    return 4 * lvl;
`else
    return 64 + 0 * lvl;
`endif
  endfunction

  // Starts in a frame's first cycle, runs to the next Frame_Tick and checks the frame.
  task automatic measure(input string tag, input int exp_len, input int exp_h0, input int exp_h1v,
                         input bit mid_en, input logic [3:0] mid_mode, input logic [15:0] mid_duty,
                         input bit gap_en);
    int off, h0, h1, first0, gap_bad;
    off = 0; h0 = 0; h1 = 0; first0 = -1; gap_bad = 0;
    for (int guard = 0; guard < 2000; guard++) begin
      if (LED_Out[0]) begin
        h0++;
        if (first0 < 0) first0 = off;
      end
      if (LED_Out[1]) h1++;
      if (gap_en && off >= 513 && off <= 562 && LED_Out != 2'b00) gap_bad++;
      if (mid_en && off == 512) begin
        Mode = mid_mode;
        Duty = mid_duty;
      end
      if (gap_en && off == 512) EN = 1'b0;
      if (gap_en && off == 562) EN = 1'b1;
      step();
      off++;
      if (Frame_Tick) break;
    end
    chk($sformatf("%s.len", tag), off, exp_len);
    chk($sformatf("%s.high0", tag), h0, exp_h0);
    chk($sformatf("%s.high1", tag), h1, exp_h1v);
    if (exp_h0 > 0) chk($sformatf("%s.first0", tag), first0, 1);
    if (gap_en) chk($sformatf("%s.gap_dark", tag), gap_bad, 0);
    $display("frame %s: len=%0d high0=%0d high1=%0d first0=%0d", tag, off, h0, h1, first0);
  endtask

  initial begin
    RST  = 1'b1;
    EN   = 1'b0;
    Mode = {2'b11, 2'b10};
    Duty = {8'd16, 8'd64};

    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d.led", i), int'(LED_Out), 0);
      chk($sformatf("rst%0d.tick", i), int'(Frame_Tick), 0);
    end

    RST = 1'b0;
    EN  = 1'b1;
    // First frame after reset: shadows still off, tick lands 1024 cycles after release.
    measure("f0", 1024, 0, 0, 1'b0, 4'h0, 16'h0, 1'b0);
    measure("f1", 1024, 256, exp_h1(1), 1'b0, 4'h0, 16'h0, 1'b0);
    // Duty change at midpoint must wait for the next frame.
    measure("f2", 1024, 256, exp_h1(2), 1'b1, {2'b11, 2'b10}, {8'd16, 8'd192}, 1'b0);
    measure("f3", 1024, 768, exp_h1(3), 1'b0, 4'h0, 16'h0, 1'b0);
    // EN gap of 50 cycles plus a mid-frame mode change to 01 on ch0.
    measure("f4", 1074, 768, exp_h1(4), 1'b1, {2'b11, 2'b01}, {8'd16, 8'd192}, 1'b1);
    measure("f5", 1024, 1023, exp_h1(5), 1'b0, 4'h0, 16'h0, 1'b0);

    // Now sitting in a Frame_Tick cycle with modes 01/11 active.
    chk("tick_before_rst", int'(Frame_Tick), 1);
    RST = 1'b1;
    step();
    chk("rst_mid.led", int'(LED_Out), 0);
    chk("rst_mid.tick", int'(Frame_Tick), 0);
    RST = 1'b0;
    measure("r0", 1024, 0, 0, 1'b0, 4'h0, 16'h0, 1'b0);
    measure("r1", 1024, 1023, exp_h1(1), 1'b0, 4'h0, 16'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
